jk_excitation_driver: RTL and testbench
=======================================

// Module: jk_excitation_driver
// PURPOSE
//  Drive side of the JK flip-flop interface: accepts target words on a valid/ready
//  handshake and computes per-bit J/K excitation from the live Q of an external bank
//  of WIDTH JK flip-flops. Pulses J/K for one clock, waits, then checks Q against the
//  target, retrying on mismatch. Sits between a sequencing controller and the JK bank.
// PARAMETERS
//  WIDTH      4  number of JK flip-flops driven (bits in Target/Q_fb/J/K)
//  USE_TOGGLE 1  1: changing bits use J=K=1 (toggle); 0: changing bits use J=t,K=~t
//  SETTLE     1  idle cycles (J=K=0) between drive pulse and Q check, range 0..15
//  MAX_RETRY  2  extra drive attempts after first mismatch before Err, range 0..7
// PORTS
//  Clk         in   1      rising-edge clock, shared with the JK bank
//  Reset       in   1      asynchronous, active-low reset
//  Target      in   WIDTH  requested next value of the JK bank
//  In_Valid    in   1      Target valid
//  In_Ready    out  1      block can accept Target (high only in IDLE)
//  Q_fb        in   WIDTH  Q outputs of the external JK bank
//  J           out  WIDTH  J inputs to the bank
//  K           out  WIDTH  K inputs to the bank
//  Busy        out  1      transaction in progress (not IDLE)
//  Done        out  1      1-cycle pulse: Q_fb matched Target
//  Err         out  1      1-cycle pulse: retries exhausted, Q_fb != Target
//  Toggle_Cnt  out  16     count of bit-pulses driven with J=K=1, wraps at 16'hFFFF->0
// BEHAVIOUR
//  Reset (Reset=0, async): state IDLE; J=K=0; In_Ready=1; Busy=Done=Err=0;
//   Toggle_Cnt=0; retry and settle counters=0; target register=0.
//  States: IDLE -> DRIVE -> SETTLE -> CHECK -> {IDLE | DRIVE}.
//  IDLE: In_Ready=1. In_Valid&In_Ready at edge: latch Target, go DRIVE, retry cnt=0.
//  DRIVE (exactly 1 cycle): per bit i, q=Q_fb[i] (live), t=target[i]:
//   q==t            -> J=0,K=0 (hold) in both modes
//   q!=t, TOGGLE=1  -> J=1,K=1
//   q!=t, TOGGLE=0  -> J=t,K=~t
//   Toggle_Cnt += number of bits with J=K=1 in this cycle (mod 2^16).
//   Bank updates at the edge ending DRIVE. Next: SETTLE if SETTLE>0 else CHECK.
//  SETTLE: J=K=0 for SETTLE cycles, then CHECK.
//  CHECK (1 cycle, J=K=0): Q_fb==target -> Done=1, go IDLE.
//   Mismatch and retry<MAX_RETRY -> retry++, go DRIVE (recompute from live Q_fb).
//   Mismatch and retry==MAX_RETRY -> Err=1, go IDLE.
//  J and K are zero in every state except DRIVE; never J=K=1 when TOGGLE=0.
//  Latency (match, no retry): In_Valid accept edge -> Done high SETTLE+2 cycles later.
//  Target already equal to Q_fb: DRIVE emits J=K=0; Done follows normally.
//  In_Valid while Busy: ignored (In_Ready=0); Target not re-sampled mid-transaction.
//  Done and Err never both high; next accept possible the cycle after Done/Err.
//  Reset asserted mid-transaction: immediate return to reset values; J/K drop to 0
//   asynchronously; pending transaction dropped, no Done/Err.
// TESTING (WIDTH=4, SETTLE=1, MAX_RETRY=2 unless stated)
//  Reset release, Q_fb=0000, Target=1010 valid, TOGGLE=1 -> DRIVE J=1010,K=1010;
//   Done at accept+3; Toggle_Cnt=2.
//  TOGGLE=0, Q_fb=1100, Target=1010 -> J=0010,K=0100; never J&K!=0; Done pulse.
//  Target==Q_fb=0110 -> J=K=0000 all cycles; Done; Toggle_Cnt unchanged.
//  Bank model with bit0 stuck at 0, Target=0001 -> 3 DRIVE pulses, then Err=1 at
//   accept+9, Done never asserted; MAX_RETRY=0 -> Err at accept+3.
//  In_Valid held high with changing Target during Busy -> only first Target driven;
//   second accepted cycle after Done.
//  Reset low during SETTLE -> J=K=0, In_Ready=1, Busy=0, Toggle_Cnt=0 same cycle.

Source files
------------

// File: rtl/jk_excitation_driver.sv
// Drive side of a JK flip-flop bank: accepts a target word, pulses per-bit J/K excitation
// computed from the live bank Q, waits, verifies Q and retries a bounded number of times.
module jk_excitation_driver #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned USE_TOGGLE = 1,
  parameter int unsigned SETTLE     = 1,
  parameter int unsigned MAX_RETRY  = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Target,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] Q_fb,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             Busy,
  output logic             Done,
  output logic             Err,
  output logic [15:0]      Toggle_Cnt
);

  typedef enum logic [1:0] {StIdle, StDrive, StSettle, StCheck} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [2:0]       retry_q, retry_d;
  logic [3:0]       settle_q, settle_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] diff;

  function automatic logic [15:0] popcount(input logic [WIDTH-1:0] v);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      n = n + 16'(v[i]);
    end
    return n;
  endfunction

  assign diff = Q_fb ^ target_q;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    retry_d  = retry_q;
    settle_d = settle_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    J        = '0;
    K        = '0;
    unique case (state_q)
      StIdle: begin
        if (In_Valid) begin
          target_d = Target;
          retry_d  = '0;
          state_d  = StDrive;
        end
      end
      StDrive: begin
        // Only mismatching bits are excited; matching bits hold with J=K=0.
        if (USE_TOGGLE != 0) begin
          J = diff;
          K = diff;
        end else begin
          J = diff & target_q;
          K = diff & ~target_q;
        end
        cnt_d    = cnt_q + popcount(J & K);
        settle_d = '0;
        state_d  = (SETTLE > 0) ? StSettle : StCheck;
      end
      StSettle: begin
        if (settle_q == 4'(SETTLE - 1)) begin
          state_d = StCheck;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      StCheck: begin
        if (diff == '0) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (retry_q < 3'(MAX_RETRY)) begin
          retry_d = retry_q + 3'd1;
          state_d = StDrive;
        end else begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= StIdle;
      target_q <= '0;
      retry_q  <= '0;
      settle_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      retry_q  <= retry_d;
      settle_q <= settle_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign In_Ready   = (state_q == StIdle);
  assign Busy       = (state_q != StIdle);
  assign Done       = done_q;
  assign Err        = err_q;
  assign Toggle_Cnt = cnt_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: three parameterisations, each driving a behavioural JK bank
// with optional stuck-at-0 bits, checked against a transaction-level reference model.
module tb_jk_excitation_driver;

  localparam int TG[3] = '{1, 0, 1};
  localparam int MR[3] = '{2, 2, 0};
  localparam int PER   = 3;  // SETTLE + 2 for every instance

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  tgt[3];
  logic        vld[3];
  logic        rdy[3];
  logic [3:0]  qb[3];
  logic [3:0]  jj[3];
  logic [3:0]  kk[3];
  logic        busy[3];
  logic        done[3];
  logic        err[3];
  logic [15:0] cnt[3];
  logic [3:0]  stuck[3];
  logic [3:0]  ld_val[3];
  logic        ld[3];

  int checks = 0;
  int failures = 0;
  int exp_cnt[3];

  always #5 clk = ~clk;

  jk_excitation_driver #(.WIDTH(4), .USE_TOGGLE(1), .SETTLE(1), .MAX_RETRY(2)) dut0 (
    .Clk(clk), .Reset(rst_n), .Target(tgt[0]), .In_Valid(vld[0]), .In_Ready(rdy[0]),
    .Q_fb(qb[0]), .J(jj[0]), .K(kk[0]), .Busy(busy[0]), .Done(done[0]), .Err(err[0]),
    .Toggle_Cnt(cnt[0])
  );
  jk_excitation_driver #(.WIDTH(4), .USE_TOGGLE(0), .SETTLE(1), .MAX_RETRY(2)) dut1 (
    .Clk(clk), .Reset(rst_n), .Target(tgt[1]), .In_Valid(vld[1]), .In_Ready(rdy[1]),
    .Q_fb(qb[1]), .J(jj[1]), .K(kk[1]), .Busy(busy[1]), .Done(done[1]), .Err(err[1]),
    .Toggle_Cnt(cnt[1])
  );
  jk_excitation_driver #(.WIDTH(4), .USE_TOGGLE(1), .SETTLE(1), .MAX_RETRY(0)) dut2 (
    .Clk(clk), .Reset(rst_n), .Target(tgt[2]), .In_Valid(vld[2]), .In_Ready(rdy[2]),
    .Q_fb(qb[2]), .J(jj[2]), .K(kk[2]), .Busy(busy[2]), .Done(done[2]), .Err(err[2]),
    .Toggle_Cnt(cnt[2])
  );

  // External JK bank: Qn = J&~Q | ~K&Q, stuck bits forced to 0.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ld[i]) qb[i] <= ld_val[i] & ~stuck[i];
      else       qb[i] <= ((jj[i] & ~qb[i]) | (~kk[i] & qb[i])) & ~stuck[i];
    end
  end

  task automatic set_bank(input int u, input logic [3:0] v);
    @(negedge clk);
    ld[u] = 1'b1;
    ld_val[u] = v;
    @(posedge clk);
    #1 ld[u] = 1'b0;
  endtask

  // Transaction-level reference: each drive moves the bank to target except stuck bits.
  task automatic model(input int u, input logic [3:0] q0, input logic [3:0] t,
                       input logic [3:0] st, output int n, output bit dn, output int inc);
    logic [3:0] qe, d;
    qe = q0 & ~st;
    n = 0; inc = 0; dn = 1'b0;
    for (int a = 0; a <= MR[u]; a++) begin
      d = qe ^ t;
      n++;
      if (TG[u] == 1) inc += $countones(d);
      qe = t & ~st;
      if (qe == t) begin
        dn = 1'b1;
        break;
      end
    end
  endtask

  // Drives one transaction and records what the DUT did; the callers judge it.
  task automatic run_txn(input int u, input logic [3:0] t, output int lat,
                         output logic [3:0] j0, output logic [3:0] k0, output bit dn,
                         output bit er, output bit ovl, output bit stray);
    @(negedge clk);
    tgt[u] = t;
    vld[u] = 1'b1;
    @(posedge clk);
    #1 vld[u] = 1'b0;
    lat = -1; j0 = '0; k0 = '0; dn = 0; er = 0; ovl = 0; stray = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (c == 0) begin
        j0 = jj[u];
        k0 = kk[u];
      end
      if ((jj[u] & kk[u]) != 0 && TG[u] == 0) ovl = 1;
      if ((jj[u] | kk[u]) != 0 && (c % PER) != 0) stray = 1;
      if (done[u] === 1'b1 || err[u] === 1'b1) begin
        dn = done[u];
        er = err[u];
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 0; tgt[i] = '0; stuck[i] = '0; ld[i] = 0; ld_val[i] = '0; exp_cnt[i] = 0;
    end
    for (int i = 0; i < 3; i++) set_bank(i, 4'b0000);
    #2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdy[i] !== 1'b1 || busy[i] !== 1'b0 || done[i] !== 1'b0 || err[i] !== 1'b0 ||
          jj[i] !== 4'h0 || kk[i] !== 4'h0 || cnt[i] !== 16'h0) begin
        failures++;
        $display("FAIL reset_state u%0d: rdy=%b busy=%b done=%b err=%b J=%h K=%h cnt=%h, need 1 0 0 0 0 0 0",
                 i, rdy[i], busy[i], done[i], err[i], jj[i], kk[i], cnt[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int u; logic [3:0] q0, t, st, ej, ek; int lat; bit dn; int inc;
  } dir_t;

  task automatic test_directed();
    dir_t tbl[6];
    int lat; logic [3:0] j0, k0; bit dn, er, ovl, stray;
    tbl[0] = '{0, 4'b0000, 4'b1010, 4'b0000, 4'b1010, 4'b1010, 3, 1, 2};
    tbl[1] = '{1, 4'b1100, 4'b1010, 4'b0000, 4'b0010, 4'b0100, 3, 1, 0};
    tbl[2] = '{0, 4'b0110, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 3, 1, 0};
    tbl[3] = '{0, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 9, 0, 3};
    tbl[4] = '{2, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 3, 0, 1};
    tbl[5] = '{1, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 9, 0, 0};
    for (int n = 0; n < 6; n++) begin
      stuck[tbl[n].u] = tbl[n].st;
      set_bank(tbl[n].u, tbl[n].q0);
      run_txn(tbl[n].u, tbl[n].t, lat, j0, k0, dn, er, ovl, stray);
      exp_cnt[tbl[n].u] += tbl[n].inc;
      checks++;
      if (j0 !== tbl[n].ej || k0 !== tbl[n].ek) begin
        failures++;
        $display("FAIL dir%0d_jk: J=%b K=%b, need J=%b K=%b", n, j0, k0, tbl[n].ej, tbl[n].ek);
      end
      checks++;
      if (lat != tbl[n].lat || dn != tbl[n].dn || er == tbl[n].dn) begin
        failures++;
        $display("FAIL dir%0d_outcome: lat=%0d done=%b err=%b, need lat=%0d done=%b err=%b",
                 n, lat, dn, er, tbl[n].lat, tbl[n].dn, !tbl[n].dn);
      end
      checks++;
      if (ovl || stray) begin
        failures++;
        $display("FAIL dir%0d_jk_rules: overlap=%b stray=%b, need 0 0", n, ovl, stray);
      end
      checks++;
      if (cnt[tbl[n].u] !== 16'(exp_cnt[tbl[n].u])) begin
        failures++;
        $display("FAIL dir%0d_cnt: %0d, need %0d", n, cnt[tbl[n].u], exp_cnt[tbl[n].u]);
      end
      stuck[tbl[n].u] = '0;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] t1, t2;
    int lat;
    t1 = 4'b0101;
    t2 = 4'b0011;
    set_bank(0, 4'b0000);
    @(negedge clk);
    tgt[0] = t1;
    vld[0] = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (jj[0] !== t1 || kk[0] !== t1) begin
          failures++;
          $display("FAIL b2b_first_jk: J=%b K=%b, need %b", jj[0], kk[0], t1);
        end
      end
      if (done[0] === 1'b1 || err[0] === 1'b1) begin
        lat = c;
        tgt[0] = t2;
        break;
      end
      tgt[0] = 4'($urandom);
    end
    checks++;
    if (lat != PER || done[0] !== 1'b1 || qb[0] !== t1) begin
      failures++;
      $display("FAIL b2b_first_done: lat=%0d done=%b Q=%b, need lat=%0d done=1 Q=%b",
               lat, done[0], qb[0], PER, t1);
    end
    @(posedge clk);
    #1 vld[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1 || jj[0] !== (t1 ^ t2) || kk[0] !== (t1 ^ t2)) begin
      failures++;
      $display("FAIL b2b_second_drive: busy=%b J=%b K=%b, need busy=1 J=K=%b",
               busy[0], jj[0], kk[0], t1 ^ t2);
    end
    lat = -1;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      if (done[0] === 1'b1 || err[0] === 1'b1) begin
        lat = c;
        break;
      end
    end
    exp_cnt[0] += 4;
    checks++;
    if (lat != PER || qb[0] !== t2 || cnt[0] !== 16'(exp_cnt[0])) begin
      failures++;
      $display("FAIL b2b_second_done: lat=%0d Q=%b cnt=%0d, need lat=%0d Q=%b cnt=%0d",
               lat, qb[0], cnt[0], PER, t2, exp_cnt[0]);
    end
  endtask

  task automatic test_random();
    int u, lat, en, inc;
    logic [3:0] q0, t, st, d0, ej, ek, j0, k0;
    bit edn, dn, er, ovl, stray;
    for (int n = 0; n < 40; n++) begin
      u  = $urandom_range(0, 2);
      q0 = 4'($urandom);
      t  = 4'($urandom);
      st = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      stuck[u] = st;
      set_bank(u, q0);
      model(u, q0, t, st, en, edn, inc);
      d0 = (q0 & ~st) ^ t;
      ej = (TG[u] == 1) ? d0 : (d0 & t);
      ek = (TG[u] == 1) ? d0 : (d0 & ~t);
      exp_cnt[u] += inc;
      run_txn(u, t, lat, j0, k0, dn, er, ovl, stray);
      checks++;
      if (lat != en * PER || dn != edn || er == edn || j0 !== ej || k0 !== ek || ovl || stray) begin
        failures++;
        $display("FAIL rnd%0d u%0d q=%b t=%b st=%b: lat=%0d done=%b err=%b J=%b K=%b ovl=%b stray=%b, need lat=%0d done=%b J=%b K=%b",
                 n, u, q0, t, st, lat, dn, er, j0, k0, ovl, stray, en * PER, edn, ej, ek);
      end
      checks++;
      if (cnt[u] !== 16'(exp_cnt[u]) || qb[u] !== (t & ~st)) begin
        failures++;
        $display("FAIL rnd%0d_state u%0d: cnt=%0d Q=%b, need cnt=%0d Q=%b",
                 n, u, cnt[u], qb[u], exp_cnt[u], t & ~st);
      end
      stuck[u] = '0;
    end
  endtask

  task automatic test_reset_mid();
    bit stray_pulse;
    set_bank(0, 4'b0000);
    @(negedge clk);
    tgt[0] = 4'b1111;
    vld[0] = 1'b1;
    @(posedge clk);
    #1 vld[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    checks++;
    if (jj[0] !== 4'h0 || kk[0] !== 4'h0 || rdy[0] !== 1'b1 || busy[0] !== 1'b0 ||
        cnt[0] !== 16'h0) begin
      failures++;
      $display("FAIL reset_in_settle: J=%h K=%h rdy=%b busy=%b cnt=%0d, need 0 0 1 0 0",
               jj[0], kk[0], rdy[0], busy[0], cnt[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_bank(0, 4'b0000);
    @(negedge clk);
    tgt[0] = 4'b0110;
    vld[0] = 1'b1;
    @(posedge clk);
    #1 vld[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (jj[0] !== 4'h0 || kk[0] !== 4'h0 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_drive: J=%h K=%h busy=%b, need 0 0 0", jj[0], kk[0], busy[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray_pulse = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done[0] !== 1'b0 || err[0] !== 1'b0 || busy[0] !== 1'b0) stray_pulse = 1;
    end
    checks++;
    if (stray_pulse || cnt[0] !== 16'h0) begin
      failures++;
      $display("FAIL reset_drops_txn: activity=%b cnt=%0d, need 0 0", stray_pulse, cnt[0]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
